fifo_sync_fwft: RTL and testbench
=================================

// Module: fifo_sync_fwft
// PURPOSE
//   Parametrised single-clock FIFO for the fabric: configurable data width and depth,
//   standard or first-word-fall-through (FWFT) read mode, live fill count, and
//   programmable watermarks. Storage is an inferred dual-port RAM with an output register.
//   It replaces fixed-geometry 36K FIFO instances where the geometry or read mode differs.
// PARAMETERS
//   DATA_WIDTH        36    word width, 1..72
//   DEPTH             1024  number of words; power of 2, 4..32768
//   FWFT              1'b0  0 = standard read, 1 = first-word-fall-through
//   PROG_FULL_THRESH  768   PROG_FULL is high when FILL_COUNT >= value; range 1..DEPTH-1
//   PROG_EMPTY_THRESH 4     PROG_EMPTY is high when FILL_COUNT <= value; range 1..DEPTH-1
//   CW (localparam)         $clog2(DEPTH)+1
// PORTS
//   CLK           in   1           single clock; all logic is on the rising edge
//   RESET         in   1           synchronous reset, active-high
//   WR_DATA       in   DATA_WIDTH  write data
//   WREN          in   1           write request
//   RDEN          in   1           read request (pop, when FWFT=1)
//   RD_DATA       out  DATA_WIDTH  read data, registered
//   EMPTY         out  1           no readable word
//   FULL          out  1           FILL_COUNT == DEPTH
//   ALMOST_EMPTY  out  1           FILL_COUNT == 1
//   ALMOST_FULL   out  1           FILL_COUNT == DEPTH-1
//   PROG_EMPTY    out  1           FILL_COUNT <= PROG_EMPTY_THRESH
//   PROG_FULL     out  1           FILL_COUNT >= PROG_FULL_THRESH
//   OVERFLOW      out  1           write was rejected on the previous edge
//   UNDERFLOW     out  1           read was rejected on the previous edge
//   FILL_COUNT    out  CW          words held, including the FWFT output stage
// BEHAVIOUR
//   - Elaboration: a parameter outside its legal range triggers $error and $finish.
//   - Reset (RESET=1 at an edge): clears the pointers and FILL_COUNT, and sets
//     RD_DATA=0, EMPTY=1, PROG_EMPTY=1. All other flags go to 0.
//     WREN and RDEN are ignored while RESET=1. Reset mid-operation discards all contents.
//   - Write accept: WREN & !FULL. Write reject: WREN & FULL, even if RDEN is high in the
//     same cycle. A rejected write leaves memory and the count unchanged and sets
//     OVERFLOW=1 for exactly one cycle.
//   - Read accept: RDEN & !EMPTY. Read reject: RDEN & EMPTY. A rejected read sets
//     UNDERFLOW=1 for one cycle. RD_DATA then holds its previous value.
//   - Pointers are CW-1 bits wide and wrap from DEPTH-1 to 0 with no gap.
//   - FILL_COUNT updates at the edge: +1 for write only, -1 for read only,
//     unchanged when both are accepted.
//   - All flags are registered and reflect the post-edge state, with no extra lag.
//   - Standard mode (FWFT=0):
//     - RD_DATA is the popped word, valid in the cycle after the accepting edge.
//     - EMPTY = (FILL_COUNT==0).
//   - FWFT mode (FWFT=1):
//     - The head word is presented on RD_DATA while EMPTY=0. RDEN pops it.
//     - A write into an empty FIFO at edge N makes FILL_COUNT=1 after N; EMPTY falls
//       and RD_DATA shows the word after edge N+1.
//     - On a pop with more words stored, the next word appears after the same edge,
//       so back-to-back pops run at 1 word/cycle.
//     - EMPTY = "output stage not valid". Count-based flags still follow FILL_COUNT.
//   - Simultaneous read and write:
//     - Empty: the write is accepted and the read is rejected (UNDERFLOW).
//     - Full: the read is accepted and the write is rejected (OVERFLOW).
//     - In any other state, both are accepted.
//   - The memory is never read and written at the same address in one cycle, except in
//     the FWFT refill case. That case uses a bypass from WR_DATA to the output register.
// TESTING
//   1. Reset: drive RESET=1 for 2 cycles with WREN=RDEN=1.
//      -> EMPTY=1, PROG_EMPTY=1, FILL_COUNT=0, RD_DATA=0, OVERFLOW=UNDERFLOW=0.
//   2. Fill/drain, DEPTH=16, FWFT=0: write 0..15.
//      -> FULL after the 16th write, ALMOST_FULL at count 15.
//      Then read 16 words -> RD_DATA 0..15 in order, each 1 cycle after RDEN.
//      EMPTY after the last read.
//   3. Overflow/underflow: WREN while FULL -> OVERFLOW pulses 1 cycle, count stays 16.
//      RDEN while EMPTY -> UNDERFLOW pulses 1 cycle, RD_DATA unchanged.
//   4. FWFT=1 latency: write 0xA5 into an empty FIFO.
//      -> EMPTY low and RD_DATA=0xA5 two edges later. RDEN for 1 cycle -> EMPTY=1, count=0.
//   5. Simultaneous access, DEPTH=16:
//      - WREN&RDEN with count=5 for 40 cycles -> count stays 5; pointers wrap; data is in order.
//      - WREN&RDEN at FULL -> one read, OVERFLOW=1, count=15.
//   6. Watermarks (PROG_FULL_THRESH=12, PROG_EMPTY_THRESH=3): step the count 0->16->0.
//      -> PROG_EMPTY high at count<=3, PROG_FULL high at count>=12, both on the same edge
//      as the count change. Repeat with reset asserted at count 9 -> all state cleared.

Source files
------------

// File: rtl/fifo_sync_fwft_if.sv
// rtl/fifo_sync_fwft_if.sv - write/read handshake and status bundle for fifo_sync_fwft
interface fifo_sync_fwft_if #(
  parameter int DATA_WIDTH = 36,
  parameter int DEPTH      = 1024
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wren;
  logic                  rden;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  empty;
  logic                  full;
  logic                  almost_empty;
  logic                  almost_full;
  logic                  prog_empty;
  logic                  prog_full;
  logic                  overflow;
  logic                  underflow;
  logic [CW-1:0]         fill_count;

  modport master (
    output wr_data, wren, rden,
    input  rd_data, empty, full, almost_empty, almost_full,
           prog_empty, prog_full, overflow, underflow, fill_count
  );

  modport slave (
    input  wr_data, wren, rden,
    output rd_data, empty, full, almost_empty, almost_full,
           prog_empty, prog_full, overflow, underflow, fill_count
  );
endinterface

// File: rtl/fifo_sync_fwft.sv
// rtl/fifo_sync_fwft.sv - single-clock FIFO, standard or first-word-fall-through read
module fifo_sync_fwft #(
  parameter int DATA_WIDTH        = 36,
  parameter int DEPTH             = 1024,
  parameter bit FWFT              = 1'b0,
  parameter int PROG_FULL_THRESH  = 768,
  parameter int PROG_EMPTY_THRESH = 4
) (
  input logic             clk,
  input logic             reset,
  fifo_sync_fwft_if.slave bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int AW = CW - 1;

  if (DATA_WIDTH < 1 || DATA_WIDTH > 72 || DEPTH < 4 || DEPTH > 32768 ||
      (DEPTH & (DEPTH - 1)) != 0 ||
      PROG_FULL_THRESH < 1 || PROG_FULL_THRESH > DEPTH - 1 ||
      PROG_EMPTY_THRESH < 1 || PROG_EMPTY_THRESH > DEPTH - 1) begin : g_bad_param
    $fatal(1, "fifo_sync_fwft: parameter out of legal range");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic [CW-1:0]         count_nxt;
  logic [CW-1:0]         mem_count;
  logic                  out_valid;
  logic                  out_valid_nxt;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  mem_rd;
  logic                  bypass;

  // In FWFT mode the output register is a storage stage: mem_count excludes it.
  always_comb begin
    wr_acc        = bus.wren & ~bus.full;
    rd_acc        = bus.rden & ~bus.empty;
    mem_count     = count - CW'(out_valid);
    mem_rd        = 1'b0;
    bypass        = 1'b0;
    out_valid_nxt = 1'b0;
    if (FWFT) begin
      out_valid_nxt = out_valid;
      if ((!out_valid || rd_acc) && mem_count != '0) begin
        mem_rd = 1'b1;
      end else if (rd_acc && wr_acc) begin
        // Popping the last word while a new one arrives: wr_ptr == rd_ptr here.
        bypass = 1'b1;
      end
      if (mem_rd || bypass) begin
        out_valid_nxt = 1'b1;
      end else if (rd_acc) begin
        out_valid_nxt = 1'b0;
      end
    end else begin
      mem_rd = rd_acc;
    end

    count_nxt = count;
    if (wr_acc && !rd_acc) begin
      count_nxt = count + CW'(1);
    end else if (!wr_acc && rd_acc) begin
      count_nxt = count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && wr_acc) begin
      mem[wr_ptr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      count            <= '0;
      out_valid        <= 1'b0;
      bus.rd_data      <= '0;
      bus.empty        <= 1'b1;
      bus.full         <= 1'b0;
      bus.almost_empty <= 1'b0;
      bus.almost_full  <= 1'b0;
      bus.prog_empty   <= 1'b1;
      bus.prog_full    <= 1'b0;
      bus.overflow     <= 1'b0;
      bus.underflow    <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (mem_rd || bypass) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (mem_rd) begin
        bus.rd_data <= mem[rd_ptr];
      end else if (bypass) begin
        bus.rd_data <= bus.wr_data;
      end
      count            <= count_nxt;
      out_valid        <= out_valid_nxt;
      bus.empty        <= FWFT ? !out_valid_nxt : (count_nxt == '0);
      bus.full         <= (count_nxt == CW'(DEPTH));
      bus.almost_empty <= (count_nxt == CW'(1));
      bus.almost_full  <= (count_nxt == CW'(DEPTH - 1));
      bus.prog_empty   <= (count_nxt <= CW'(PROG_EMPTY_THRESH));
      bus.prog_full    <= (count_nxt >= CW'(PROG_FULL_THRESH));
      bus.overflow     <= bus.wren & bus.full;
      bus.underflow    <= bus.rden & bus.empty;
    end
  end

  assign bus.fill_count = count;
endmodule

// File: tb/tb_fifo_sync_fwft.sv
// tb/tb_fifo_sync_fwft.sv - directed bench for fifo_sync_fwft, standard and FWFT instances
module tb_fifo_sync_fwft;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fifo_sync_fwft_if #(.DATA_WIDTH(16), .DEPTH(16)) a_if ();
  fifo_sync_fwft_if #(.DATA_WIDTH(16), .DEPTH(16)) b_if ();

  fifo_sync_fwft #(
    .DATA_WIDTH(16), .DEPTH(16), .FWFT(1'b0),
    .PROG_FULL_THRESH(12), .PROG_EMPTY_THRESH(3)
  ) u_std (
    .clk(clk), .reset(reset), .bus(a_if.slave)
  );

  fifo_sync_fwft #(
    .DATA_WIDTH(16), .DEPTH(16), .FWFT(1'b1),
    .PROG_FULL_THRESH(12), .PROG_EMPTY_THRESH(3)
  ) u_fwft (
    .clk(clk), .reset(reset), .bus(b_if.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic a_drive(input logic w, input logic r, input logic [15:0] d);
    a_if.wren = w;
    a_if.rden = r;
    a_if.wr_data = d;
  endtask

  task automatic b_drive(input logic w, input logic r, input logic [15:0] d);
    b_if.wren = w;
    b_if.rden = r;
    b_if.wr_data = d;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    a_drive(1'b1, 1'b1, 16'hFFFF);
    b_drive(1'b1, 1'b1, 16'hFFFF);
    cyc();
    cyc();
    check("rst_empty", 32'(a_if.empty), 1);
    check("rst_prog_empty", 32'(a_if.prog_empty), 1);
    check("rst_count", 32'(a_if.fill_count), 0);
    check("rst_rd_data", 32'(a_if.rd_data), 0);
    check("rst_overflow", 32'(a_if.overflow), 0);
    check("rst_underflow", 32'(a_if.underflow), 0);
    check("rst_full", 32'(a_if.full), 0);
    check("rst_b_empty", 32'(b_if.empty), 1);
    check("rst_b_count", 32'(b_if.fill_count), 0);

    reset = 1'b0;
    a_drive(1'b0, 1'b0, 16'h0);
    b_drive(1'b0, 1'b0, 16'h0);

    // fill 0..15 with watermark checks at each step
    for (int i = 0; i < 16; i++) begin
      a_drive(1'b1, 1'b0, 16'(i));
      cyc();
      check("fill_count", 32'(a_if.fill_count), 32'(i + 1));
      check("fill_prog_empty", 32'(a_if.prog_empty), 32'(i + 1 <= 3));
      check("fill_prog_full", 32'(a_if.prog_full), 32'(i + 1 >= 12));
      check("fill_almost_full", 32'(a_if.almost_full), 32'(i + 1 == 15));
      check("fill_full", 32'(a_if.full), 32'(i + 1 == 16));
      check("fill_almost_empty", 32'(a_if.almost_empty), 32'(i + 1 == 1));
    end

    a_drive(1'b1, 1'b0, 16'hDEAD);
    cyc();
    check("ovf_pulse", 32'(a_if.overflow), 1);
    check("ovf_count", 32'(a_if.fill_count), 16);
    a_drive(1'b0, 1'b0, 16'h0);
    cyc();
    check("ovf_clear", 32'(a_if.overflow), 0);
    check("ovf_full", 32'(a_if.full), 1);

    for (int i = 0; i < 16; i++) begin
      a_drive(1'b0, 1'b1, 16'h0);
      cyc();
      check("drain_data", 32'(a_if.rd_data), 32'(i));
      check("drain_count", 32'(a_if.fill_count), 32'(15 - i));
      check("drain_empty", 32'(a_if.empty), 32'(i == 15));
      check("drain_prog_empty", 32'(a_if.prog_empty), 32'(15 - i <= 3));
      check("drain_prog_full", 32'(a_if.prog_full), 32'(15 - i >= 12));
    end

    a_drive(1'b0, 1'b1, 16'h0);
    cyc();
    check("unf_pulse", 32'(a_if.underflow), 1);
    check("unf_rd_hold", 32'(a_if.rd_data), 15);
    check("unf_count", 32'(a_if.fill_count), 0);
    a_drive(1'b0, 1'b0, 16'h0);
    cyc();
    check("unf_clear", 32'(a_if.underflow), 0);

    // steady state at count 5, 40 simultaneous cycles to wrap pointers
    for (int i = 0; i < 5; i++) begin
      a_drive(1'b1, 1'b0, 16'(100 + i));
      cyc();
    end
    for (int k = 0; k < 40; k++) begin
      a_drive(1'b1, 1'b1, 16'(105 + k));
      cyc();
      check("sim_data", 32'(a_if.rd_data), 32'(100 + k));
      check("sim_count", 32'(a_if.fill_count), 5);
    end
    for (int i = 0; i < 5; i++) begin
      a_drive(1'b0, 1'b1, 16'h0);
      cyc();
      check("sim_tail", 32'(a_if.rd_data), 32'(140 + i));
    end
    check("sim_empty", 32'(a_if.empty), 1);

    for (int i = 0; i < 16; i++) begin
      a_drive(1'b1, 1'b0, 16'(200 + i));
      cyc();
    end
    a_drive(1'b1, 1'b1, 16'hBEEF);
    cyc();
    check("full_rw_ovf", 32'(a_if.overflow), 1);
    check("full_rw_count", 32'(a_if.fill_count), 15);
    check("full_rw_data", 32'(a_if.rd_data), 200);
    check("full_rw_almost_full", 32'(a_if.almost_full), 1);
    for (int i = 0; i < 15; i++) begin
      a_drive(1'b0, 1'b1, 16'h0);
      cyc();
      check("full_rw_tail", 32'(a_if.rd_data), 32'(201 + i));
    end
    check("full_rw_empty", 32'(a_if.empty), 1);

    a_drive(1'b1, 1'b1, 16'h0077);
    cyc();
    check("empty_rw_unf", 32'(a_if.underflow), 1);
    check("empty_rw_count", 32'(a_if.fill_count), 1);
    a_drive(1'b0, 1'b1, 16'h0);
    cyc();
    check("empty_rw_data", 32'(a_if.rd_data), 16'h0077);

    // reset in the middle of operation at count 9
    for (int i = 0; i < 9; i++) begin
      a_drive(1'b1, 1'b0, 16'(300 + i));
      cyc();
    end
    check("mid_count9", 32'(a_if.fill_count), 9);
    check("mid_prog_empty9", 32'(a_if.prog_empty), 0);
    reset = 1'b1;
    a_drive(1'b1, 1'b1, 16'h0999);
    cyc();
    reset = 1'b0;
    a_drive(1'b0, 1'b0, 16'h0);
    check("mid_rst_count", 32'(a_if.fill_count), 0);
    check("mid_rst_empty", 32'(a_if.empty), 1);
    check("mid_rst_prog_empty", 32'(a_if.prog_empty), 1);
    check("mid_rst_rd_data", 32'(a_if.rd_data), 0);
    check("mid_rst_prog_full", 32'(a_if.prog_full), 0);
    a_drive(1'b1, 1'b0, 16'h0055);
    cyc();
    a_drive(1'b0, 1'b1, 16'h0);
    cyc();
    check("post_rst_data", 32'(a_if.rd_data), 16'h0055);
    check("post_rst_empty", 32'(a_if.empty), 1);
    a_drive(1'b0, 1'b0, 16'h0);

    // FWFT latency
    b_drive(1'b1, 1'b0, 16'h00A5);
    cyc();
    check("fwft_cnt_n", 32'(b_if.fill_count), 1);
    check("fwft_empty_n", 32'(b_if.empty), 1);
    b_drive(1'b0, 1'b0, 16'h0);
    cyc();
    check("fwft_empty_n1", 32'(b_if.empty), 0);
    check("fwft_data_n1", 32'(b_if.rd_data), 16'h00A5);
    b_drive(1'b0, 1'b1, 16'h0);
    cyc();
    check("fwft_pop_empty", 32'(b_if.empty), 1);
    check("fwft_pop_count", 32'(b_if.fill_count), 0);
    cyc();
    check("fwft_unf", 32'(b_if.underflow), 1);

    // FWFT back-to-back pops
    b_drive(1'b1, 1'b0, 16'h0001);
    cyc();
    b_drive(1'b1, 1'b0, 16'h0002);
    cyc();
    check("fwft_b2b_head", 32'(b_if.rd_data), 1);
    check("fwft_b2b_empty", 32'(b_if.empty), 0);
    b_drive(1'b1, 1'b0, 16'h0003);
    cyc();
    check("fwft_b2b_cnt3", 32'(b_if.fill_count), 3);
    b_drive(1'b0, 1'b1, 16'h0);
    cyc();
    check("fwft_pop1", 32'(b_if.rd_data), 2);
    check("fwft_pop1_cnt", 32'(b_if.fill_count), 2);
    cyc();
    check("fwft_pop2", 32'(b_if.rd_data), 3);
    check("fwft_pop2_cnt", 32'(b_if.fill_count), 1);
    cyc();
    check("fwft_pop3_empty", 32'(b_if.empty), 1);
    check("fwft_pop3_cnt", 32'(b_if.fill_count), 0);

    // FWFT refill bypass: pop the only word while writing a new one
    b_drive(1'b1, 1'b0, 16'h0011);
    cyc();
    b_drive(1'b0, 1'b0, 16'h0);
    cyc();
    check("fwft_byp_head", 32'(b_if.rd_data), 16'h0011);
    b_drive(1'b1, 1'b1, 16'h0022);
    cyc();
    check("fwft_byp_data", 32'(b_if.rd_data), 16'h0022);
    check("fwft_byp_empty", 32'(b_if.empty), 0);
    check("fwft_byp_count", 32'(b_if.fill_count), 1);
    b_drive(1'b0, 1'b1, 16'h0);
    cyc();
    check("fwft_byp_drain", 32'(b_if.empty), 1);
    b_drive(1'b0, 1'b0, 16'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
